hazard_ctrl: RTL

Pipeline hazard and stall controller for the five-stage RISC-V core. It is the control end of the ID/EX pipeline-register interface. It observes the decoded operands in ID, the load/branch status in EX, and the data-memory handshake in MEM. From these it drives the enable and bubble/flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also keeps hazard performance counters and a memory-timeout watchdog.

---
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage core: pipeline enables/flushes,
// hazard performance counters and a data-memory timeout watchdog.
//
// state  | meaning
// S_RUN  | no data-memory access outstanding
// S_WAIT | MEM stage waiting on dmem_ready, pipe frozen
module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_Rs1,
  input  logic [4:0]       id_Rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_Rd,
  input  logic             ex_Rd_EQ0,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  localparam logic [15:0] WD_MAX = 16'(TIMEOUT);
  localparam logic [15:0] WD_TRIP = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [15:0] wd;
  logic        mem_stall, load_use;
  logic        act_wait, act_flush, act_bubble;

  assign mem_stall = mem_req & ~dmem_ready;
  assign load_use  = ex_MemRead & ~ex_Rd_EQ0 &
                     ((id_uses_rs1 & (id_Rs1 == ex_Rd)) | (id_uses_rs2 & (id_Rs2 == ex_Rd)));

  // Exactly one action is selected per cycle; a stall holds any pending redirect in EX.
  assign act_wait   = mem_stall;
  assign act_flush  = ~mem_stall & ex_redirect;
  assign act_bubble = ~mem_stall & ~ex_redirect & load_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    case (state)
      S_RUN:  if (mem_stall) state_next = S_WAIT;
      S_WAIT: if (dmem_ready) state_next = S_RUN;
      default: state_next = S_RUN;
    endcase
    if (!rst) begin
      if (act_wait) begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
      end else if (act_flush) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (act_bubble) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd <= '0;
    end else if (mem_stall) begin
      if (wd != WD_MAX) wd <= wd + 16'd1;
    end else begin
      wd <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_timeout <= 1'b0;
      bubble_cnt  <= '0;
      wait_cnt    <= '0;
      flush_cnt   <= '0;
    end else if (cnt_clr) begin
      mem_timeout <= 1'b0;
      bubble_cnt  <= '0;
      wait_cnt    <= '0;
      flush_cnt   <= '0;
    end else begin
      if (mem_stall && wd == WD_TRIP) mem_timeout <= 1'b1;
      if (act_bubble) bubble_cnt <= bubble_cnt + 1'b1;
      if (act_wait)   wait_cnt   <= wait_cnt + 1'b1;
      if (act_flush)  flush_cnt  <= flush_cnt + 1'b1;
    end
  end

endmodule
